// File: rtl/hack_cpu_core.sv
// Hack CPU control core: a 3-clock FETCH/DECODE/EXEC sequencer around the combinational
// Hack ALU, sized for 1-cycle-latency block RAM on both the instruction and data ports.

module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_zero_s;
  logic [15:0] x_neg_s;
  logic [15:0] y_zero_s;
  logic [15:0] y_neg_s;
  logic [15:0] fn_s;

  assign x_zero_s = zx ? 16'h0000 : x;
  assign x_neg_s  = nx ? ~x_zero_s : x_zero_s;
  assign y_zero_s = zy ? 16'h0000 : y;
  assign y_neg_s  = ny ? ~y_zero_s : y_zero_s;
  assign fn_s     = f ? (x_neg_s + y_neg_s) : (x_neg_s & y_neg_s);
  assign out      = no ? ~fn_s : fn_s;
  assign zr       = (out == 16'h0000);
  assign ng       = out[15];
endmodule

module hack_cpu_core #(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] pc
);
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t            state_r;
  logic [15:0]       a_r;
  logic [15:0]       d_r;
  logic [15:0]       ir_r;
  logic [ADDR_W-1:0] pc_r;

  logic [15:0]       alu_y_s;
  logic [15:0]       alu_out_s;
  logic              alu_zr_s;
  logic              alu_ng_s;
  logic              jump_s;
  logic [ADDR_W-1:0] pc_inc_s;

  // A is stable from DECODE through EXEC, so ram_rdata is already valid for the M operand.
  assign alu_y_s  = ir_r[12] ? ram_rdata : a_r;
  assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  alu u_alu (
    .x  (d_r),
    .y  (alu_y_s),
    .zx (ir_r[11]),
    .nx (ir_r[10]),
    .zy (ir_r[9]),
    .ny (ir_r[8]),
    .f  (ir_r[7]),
    .no (ir_r[6]),
    .out(alu_out_s),
    .zr (alu_zr_s),
    .ng (alu_ng_s)
  );

  // Jump resolution from the selected ALU flag conditions of a C-instruction.
  always_comb begin
    jump_s = 1'b0;
    if (ir_r[15]) begin
      jump_s = (ir_r[2] & alu_ng_s)
             | (ir_r[1] & alu_zr_s)
             | (ir_r[0] & ~alu_ng_s & ~alu_zr_s);
    end else begin
      jump_s = 1'b0;
    end
  end

  // Sequencer and architectural registers; every A/D/PC update lands at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      a_r     <= 16'h0000;
      d_r     <= 16'h0000;
      ir_r    <= 16'h0000;
      pc_r    <= RESET_PC;
    end else begin
      case (state_r)
        FETCH: begin
          state_r <= DECODE;
        end
        DECODE: begin
          ir_r    <= rom_data;
          state_r <= EXEC;
        end
        EXEC: begin
          state_r <= FETCH;
          if (!ir_r[15]) begin
            a_r  <= {1'b0, ir_r[14:0]};
            pc_r <= pc_inc_s;
          end else begin
            if (ir_r[5]) begin
              a_r <= alu_out_s;
            end
            if (ir_r[4]) begin
              d_r <= alu_out_s;
            end
            // Jump target uses A as it stood before this instruction's own A write.
            pc_r <= jump_s ? a_r[ADDR_W-1:0] : pc_inc_s;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  assign rom_addr  = pc_r;
  assign pc        = pc_r;
  assign ram_addr  = a_r[ADDR_W-1:0];
  assign ram_wdata = alu_out_s;
  assign ram_we    = (state_r == EXEC) & ir_r[15] & ir_r[3] & ~reset;
endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core: behavioural 1-cycle-latency ROM/RAM and hand-encoded programs.

module tb_hack_cpu_core;
  logic        clk;
  logic        reset;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [14:0] ram_addr;
  logic [15:0] ram_rdata;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [14:0] pc;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];
  logic        tb_we;
  logic [14:0] tb_waddr;
  logic [15:0] tb_wdata;

  int checks;
  int failures;

  hack_cpu_core #(.ADDR_W(15), .RESET_PC(15'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_addr (ram_addr),
    .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .pc       (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories; bench preload port has priority over CPU writes.
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    ram_rdata <= ram[ram_addr];
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
  endtask

  task automatic poke(input logic [14:0] addr, input logic [15:0] val);
    tb_we = 1'b1; tb_waddr = addr; tb_wdata = val;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_rom();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_we_held: got %b expected 0", ram_we); end
    apply_reset();
    checks++; if (pc !== 15'd0) begin failures++; $display("FAIL rst_pc: got %0d expected 0", pc); end
    checks++; if (rom_addr !== 15'd0) begin failures++; $display("FAIL rst_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (dut.a_r !== 16'h0000) begin failures++; $display("FAIL rst_a: got %h expected 0000", dut.a_r); end
    checks++; if (dut.d_r !== 16'h0000) begin failures++; $display("FAIL rst_d: got %h expected 0000", dut.d_r); end
    checks++; if (dut.state_r !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", dut.state_r); end
  endtask

  task automatic test_add_store();
    int we_count;
    int we_cycle;
    logic [14:0] we_addr;
    logic [15:0] we_data;
    clear_rom();
    rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003;
    rom[3] = 16'hE090; rom[4] = 16'h0000; rom[5] = 16'hE308;
    reset = 1'b1;
    @(negedge clk);
    poke(15'd0, 16'hDEAD);
    apply_reset();
    we_count = 0; we_cycle = 0; we_addr = 15'd0; we_data = 16'h0000;
    for (int n = 1; n <= 18; n++) begin
      if (ram_we === 1'b1) begin
        we_count++; we_cycle = n; we_addr = ram_addr; we_data = ram_wdata;
      end
      @(negedge clk);
    end
    checks++; if (we_count !== 1) begin failures++; $display("FAIL add_we_count: got %0d expected 1", we_count); end
    checks++; if (we_cycle !== 18) begin failures++; $display("FAIL add_we_cycle: got %0d expected 18", we_cycle); end
    checks++; if (we_addr !== 15'd0) begin failures++; $display("FAIL add_we_addr: got %0d expected 0", we_addr); end
    checks++; if (we_data !== 16'd5) begin failures++; $display("FAIL add_we_data: got %0d expected 5", we_data); end
    checks++; if (dut.d_r !== 16'd5) begin failures++; $display("FAIL add_d: got %0d expected 5", dut.d_r); end
    checks++; if (pc !== 15'd6) begin failures++; $display("FAIL add_pc: got %0d expected 6", pc); end
    checks++; if (ram[0] !== 16'd5) begin failures++; $display("FAIL add_ram0: got %h expected 0005", ram[0]); end
  endtask

  task automatic test_jump_flags();
    clear_rom();
    rom[0] = 16'h0007; rom[1] = 16'hFC10; rom[2] = 16'h000A;
    rom[3] = 16'hE304; rom[4] = 16'hE302;
    reset = 1'b1;
    @(negedge clk);
    poke(15'd7, 16'hFFFE);
    apply_reset();
    run(12);
    checks++; if (dut.d_r !== 16'hFFFE) begin failures++; $display("FAIL jlt_d: got %h expected fffe", dut.d_r); end
    checks++; if (pc !== 15'd10) begin failures++; $display("FAIL jlt_taken_pc: got %0d expected 10", pc); end
    reset = 1'b1;
    @(negedge clk);
    poke(15'd7, 16'h0000);
    apply_reset();
    run(12);
    checks++; if (pc !== 15'd4) begin failures++; $display("FAIL jlt_not_taken_pc: got %0d expected 4", pc); end
    run(3);
    checks++; if (pc !== 15'd10) begin failures++; $display("FAIL jeq_pc: got %0d expected 10", pc); end
  endtask

  task automatic test_jmp_am();
    clear_rom();
    rom[0] = 16'h0014; rom[1] = 16'hEDEF;
    reset = 1'b1;
    @(negedge clk);
    poke(15'd20, 16'h0000);
    apply_reset();
    run(5);
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL am_we: got %b expected 1", ram_we); end
    checks++; if (ram_addr !== 15'd20) begin failures++; $display("FAIL am_addr: got %0d expected 20", ram_addr); end
    checks++; if (ram_wdata !== 16'd21) begin failures++; $display("FAIL am_wdata: got %0d expected 21", ram_wdata); end
    run(1);
    checks++; if (pc !== 15'd20) begin failures++; $display("FAIL am_pc: got %0d expected 20", pc); end
    checks++; if (dut.a_r !== 16'd21) begin failures++; $display("FAIL am_a: got %0d expected 21", dut.a_r); end
    checks++; if (ram[20] !== 16'd21) begin failures++; $display("FAIL am_ram20: got %0d expected 21", ram[20]); end
  endtask

  task automatic test_const_ops();
    clear_rom();
    rom[0] = 16'h00F0; rom[1] = 16'hEC10; rom[2] = 16'hE350; rom[3] = 16'hEE90;
    rom[4] = 16'h001E; rom[5] = 16'hEA81; rom[6] = 16'hEA82;
    apply_reset();
    run(9);
    checks++; if (dut.d_r !== 16'hFF0F) begin failures++; $display("FAIL not_d: got %h expected ff0f", dut.d_r); end
    run(3);
    checks++; if (dut.d_r !== 16'hFFFF) begin failures++; $display("FAIL minus1_d: got %h expected ffff", dut.d_r); end
    run(6);
    checks++; if (pc !== 15'd6) begin failures++; $display("FAIL jgt_zero_pc: got %0d expected 6", pc); end
    run(3);
    checks++; if (pc !== 15'd30) begin failures++; $display("FAIL jeq_zero_pc: got %0d expected 30", pc); end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0005;
    apply_reset();
    run(6);
    checks++; if (pc !== 15'd32767) begin failures++; $display("FAIL wrap_pre_pc: got %0d expected 32767", pc); end
    run(3);
    checks++; if (pc !== 15'd0) begin failures++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
    checks++; if (rom_addr !== 15'd0) begin failures++; $display("FAIL wrap_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (dut.state_r !== 2'd0) begin failures++; $display("FAIL wrap_state: got %0d expected 0", dut.state_r); end
    checks++; if (dut.a_r !== 16'd5) begin failures++; $display("FAIL wrap_a: got %0d expected 5", dut.a_r); end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h0009; rom[3] = 16'hE308;
    reset = 1'b1;
    @(negedge clk);
    poke(15'd9, 16'h1234);
    apply_reset();
    run(11);
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL mid_we_pre: got %b expected 1", ram_we); end
    checks++; if (dut.d_r !== 16'd3) begin failures++; $display("FAIL mid_d_pre: got %0d expected 3", dut.d_r); end
    reset = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL mid_we_gated: got %b expected 0", ram_we); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dut.state_r !== 2'd0) begin failures++; $display("FAIL mid_state: got %0d expected 0", dut.state_r); end
    checks++; if (pc !== 15'd0) begin failures++; $display("FAIL mid_pc: got %0d expected 0", pc); end
    checks++; if (rom_addr !== 15'd0) begin failures++; $display("FAIL mid_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (dut.a_r !== 16'h0000) begin failures++; $display("FAIL mid_a: got %h expected 0000", dut.a_r); end
    checks++; if (dut.d_r !== 16'h0000) begin failures++; $display("FAIL mid_d: got %h expected 0000", dut.d_r); end
    checks++; if (ram[9] !== 16'h1234) begin failures++; $display("FAIL mid_ram9: got %h expected 1234", ram[9]); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; tb_we = 1'b0; tb_waddr = 15'd0; tb_wdata = 16'h0000;
    @(negedge clk);
    test_reset();
    test_add_store();
    test_jump_flags();
    test_jmp_am();
    test_const_ops();
    test_pc_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
- Hack CPU control core. It is the consumer side of the `alu` control/flag interface.
- Fetches instructions from synchronous ROM and decodes them into `alu` control bits (zx, nx, zy, ny, f, no).
- Reads `alu` flags (zr, ng) to resolve jumps, maintains A, D and PC, and reads/writes data RAM.
- Multi-cycle design: 3 clocks per instruction, matching 1-cycle-latency iCE40 BRAM on both ROM and RAM.

Parameters:
- ADDR_W, 15, width of PC, ROM address and RAM address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  instruction address; always equals PC.
- rom_data  in  16  instruction word, valid 1 clock after rom_addr is presented.
- ram_addr  out  ADDR_W  data address; always equals A[ADDR_W-1:0].
- ram_rdata  in  16  data word, valid 1 clock after ram_addr is presented.
- ram_wdata  out  16  ALU result for writes.
- ram_we  out  1  write strobe; 1-clock pulse.
- pc  out  ADDR_W  current PC (debug).

Behaviour:
- Reset (synchronous, active-high):
  - A=0, D=0, IR=0, PC=RESET_PC, state=FETCH.
  - ram_we is 0 in any cycle where reset=1; this gates any write in progress.
  - Reset asserted in any state aborts the instruction. No A/D/PC update and no RAM write occur in that cycle.
- FSM states: FETCH -> DECODE -> EXEC -> FETCH. No other transitions apart from reset.
  - FETCH: rom_addr=PC. No register updates.
  - DECODE: IR <= rom_data.
  - EXEC: executes IR as follows.
    - ram_rdata is valid here, because A is unchanged since DECODE.
    - All register updates happen at the end of EXEC.
- A-instruction (IR[15]=0): A <= {1'b0, IR[14:0]}; PC <= PC+1; ram_we=0.
- C-instruction (IR[15]=1):
  - IR[14:13] are ignored.
  - a = IR[12]: ALU y = a ? ram_rdata : A. ALU x = D.
  - IR[11:6] map to zx, nx, zy, ny, f, no, in that order.
  - Destination bits, using ALU out:
    - d1 = IR[5]: A <= out.
    - d2 = IR[4]: D <= out.
    - d3 = IR[3]: ram_we=1 during EXEC, with ram_wdata=out and ram_addr = A before update.
  - Jump bits:
    - j1 = IR[2]: jump if ng.
    - j2 = IR[1]: jump if zr.
    - j3 = IR[0]: jump if !ng & !zr.
    - The jump is taken if any selected condition holds, so j=111 is unconditional.
    - Taken: PC <= A[ADDR_W-1:0], using A before update.
    - Not taken: PC <= PC+1.
- Simultaneous A write and jump, or A write and M write: jump target and write address both use the old A.
- PC arithmetic is modulo 2^ADDR_W: 32767+1 -> 0.
- ram_we is combinational: (state==EXEC) & IR[15] & IR[3] & !reset. It is never high outside EXEC.
- The ALU is instantiated unmodified and is purely combinational.
- Flags zr and ng are used only in EXEC.

Test Plan:
- Reset then ROM {@2, D=A, @3, D=D+A, @0, M=D}:
  - ram_we pulses exactly once, in the EXEC of instruction 6, at cycle 18 after reset release.
  - Write is ram_addr=0, ram_wdata=5.
  - Final D=5, PC=6.
- Load/compare via M: RAM[7]=0xFFFE, ROM {@7, D=M, @10, D;JLT}:
  - D=0xFFFE, ng=1, so PC=10 after instruction 4.
  - Repeat with RAM[7]=0: PC=4. Then D;JEQ from PC=4 jumps to A.
- Unconditional jump with A destination: A=20, ROM "AM=A+1;JMP":
  - PC=20 (old A), RAM[20]=21, A=21.
- Constant ops (both must hold):
  - D=-1 gives D=0xFFFF.
  - D=!D with D=0x00F0 gives D=0xFF0F.
  - 0;JGT never jumps.
  - 0;JEQ always jumps.
- PC wrap: preload PC=32767 via jump, with an A-instruction at 32767.
  - Next FETCH has rom_addr=0.
- Reset mid-operation: assert reset for 1 cycle during the EXEC of an M=D instruction.
  - ram_we stays 0.
  - Next cycle: state=FETCH, PC=0, A=D=0, rom_addr=0.
